pic_instr_decoder: RTL

- Front end of the PIC-style datapath: accepts 14-bit instruction words and drives the ALU's `control`, `codigo` and `Numero_bit` inputs.
- Sequences each instruction through execute and writeback, then issues W or file write strobes.
- Resolves conditional skips (DECFSZ, INCFSZ, BTFSC, BTFSS) by discarding the following instruction word.
- Sits between the program-memory fetch stage and the ALU / register file.

---
 rtl/pic_isa_pkg.sv | 42 ++++
 rtl/pic_decode_fields.sv | 71 +++++++
 rtl/pic_instr_decoder.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/pic_isa_pkg.sv
// ISA constants, ALU class codes and FSM state type shared by the
// PIC-style instruction decoder and its field-decode sub-module.
package pic_isa_pkg;

  // ALU class codes (alu_codigo)
  localparam logic [1:0] CODE_REG    = 2'b00;
  localparam logic [1:0] CODE_BIT    = 2'b01;
  localparam logic [1:0] CODE_BRANCH = 2'b10;
  localparam logic [1:0] CODE_LIT    = 2'b11;

  // Byte-op opcodes (instr[11:8] with class 00)
  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_DECFSZ = 4'hB;
  localparam logic [3:0] OP_INCFSZ = 4'hF;

  // Bit-op ALU controls ({2'b01, instr[11:10]})
  localparam logic [3:0] OP_BCF   = 4'h4;
  localparam logic [3:0] OP_BSF   = 4'h5;
  localparam logic [3:0] OP_BTFSC = 4'h6;
  localparam logic [3:0] OP_BTFSS = 4'h7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_WB,
    ST_SKIP
  } state_e;

  typedef enum logic [1:0] {
    WR_NONE,
    WR_W,
    WR_F
  } wr_dest_e;

  typedef enum logic [1:0] {
    SK_NONE,
    SK_ZERO,
    SK_BIT_CLR,
    SK_BIT_SET
  } skip_e;

endpackage

// File: rtl/pic_decode_fields.sv
// Combinational decode of the instruction opcode bits (instr[13:7]) into
// ALU control/class/bit fields, write destination and skip classification.
// Branch decode outputs exist only when PIC_BRANCH_EN is defined.
module pic_decode_fields
  import pic_isa_pkg::*;
(
  input  logic [6:0] ir_op,       // instr[13:7]
  output logic [3:0] control,
  output logic [1:0] codigo,
  output logic [2:0] bit_idx,
  output wr_dest_e   wr_dest,
  output logic       ret,
  output skip_e      skip_type
`ifdef PIC_BRANCH_EN
  ,
  output logic       is_branch,
  output logic       is_call
`endif
);

  // Map instruction class and opcode bits to ALU fields and side effects
  always_comb begin
    control   = '0;
    codigo    = CODE_BRANCH;
    bit_idx   = '0;
    wr_dest   = WR_NONE;
    ret       = 1'b0;
    skip_type = SK_NONE;
`ifdef PIC_BRANCH_EN
    is_branch = 1'b0;
    is_call   = 1'b0;
`endif
    case (ir_op[6:5])
      CODE_REG: begin
        codigo  = CODE_REG;
        control = ir_op[4:1];
        // d=1 targets the file; d=0 targets W except the all-zero NOP
        if (ir_op[0])
          wr_dest = WR_F;
        else if (ir_op[4:1] != OP_NOP)
          wr_dest = WR_W;
        if (ir_op[4:1] == OP_DECFSZ || ir_op[4:1] == OP_INCFSZ)
          skip_type = SK_ZERO;
      end
      CODE_BIT: begin
        codigo  = CODE_BIT;
        control = {2'b01, ir_op[4:3]};
        bit_idx = ir_op[2:0];
        case ({2'b01, ir_op[4:3]})
          OP_BCF, OP_BSF: wr_dest   = WR_F;
          OP_BTFSC:       skip_type = SK_BIT_CLR;
          OP_BTFSS:       skip_type = SK_BIT_SET;
          default:        wr_dest   = WR_NONE;
        endcase
      end
      CODE_LIT: begin
        codigo  = CODE_LIT;
        control = ir_op[4:1];
        wr_dest = WR_W;
        ret     = (ir_op[4:3] == 2'b01);
      end
      default: begin
`ifdef PIC_BRANCH_EN
        is_branch = 1'b1;
        is_call   = ~ir_op[4];
`endif
      end
    endcase
  end

endmodule

// File: rtl/pic_instr_decoder.sv
// PIC-style instruction decoder front end: accepts 14-bit words, sequences
// them through EXEC and WB, issues W/file write strobes and discards the
// word after a taken conditional skip.
// Optional macro PIC_BRANCH_EN adds jump/jump_target/call_push outputs.
module pic_instr_decoder
  import pic_isa_pkg::*;
#(
  parameter int unsigned ADDR_W = 7
`ifdef PIC_BRANCH_EN
  ,
  parameter int unsigned TGT_W  = 11
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [13:0]       instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [7:0]        f_data,
  input  logic              alu_zero,
  output logic [3:0]        alu_control,
  output logic [1:0]        alu_codigo,
  output logic [2:0]        alu_bit,
  output logic [ADDR_W-1:0] file_addr,
  output logic [7:0]        literal,
  output logic              wr_w,
  output logic              wr_f,
  output logic              ret,
  output logic              skip_taken
`ifdef PIC_BRANCH_EN
  ,
  output logic              jump,
  output logic [TGT_W-1:0]  jump_target,
  output logic              call_push
`endif
);

  state_e      state_q, state_d;
  logic [13:0] ir_q, ir_d;

  logic [3:0]  dec_control;
  logic [1:0]  dec_codigo;
  logic [2:0]  dec_bit;
  wr_dest_e    dec_wr_dest;
  logic        dec_ret;
  skip_e       dec_skip;
  logic        skip_cond;
`ifdef PIC_BRANCH_EN
  logic        dec_branch;
  logic        dec_call;
`endif

  pic_decode_fields u_dec (
    .ir_op     (ir_q[13:7]),
    .control   (dec_control),
    .codigo    (dec_codigo),
    .bit_idx   (dec_bit),
    .wr_dest   (dec_wr_dest),
    .ret       (dec_ret),
    .skip_type (dec_skip)
`ifdef PIC_BRANCH_EN
    ,
    .is_branch (dec_branch),
    .is_call   (dec_call)
`endif
  );

  // ALU operand fields come straight from IR; class is forced to hold outside EXEC/WB
  assign alu_control = dec_control;
  assign alu_bit     = dec_bit;
  assign file_addr   = ir_q[ADDR_W-1:0];
  assign literal     = ir_q[7:0];
  assign alu_codigo  = (state_q == ST_EXEC || state_q == ST_WB) ? dec_codigo : CODE_BRANCH;

  // Skip condition: counters use the ALU zero flag, bit tests read f_data directly
  always_comb begin
    skip_cond = 1'b0;
    case (dec_skip)
      SK_ZERO:    skip_cond = alu_zero;
      SK_BIT_CLR: skip_cond = ~f_data[dec_bit];
      SK_BIT_SET: skip_cond = f_data[dec_bit];
      default:    skip_cond = 1'b0;
    endcase
  end

  // Next-state, IR capture and single-cycle strobes
  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    instr_ready = 1'b0;
    wr_w        = 1'b0;
    wr_f        = 1'b0;
    ret         = 1'b0;
    skip_taken  = 1'b0;
`ifdef PIC_BRANCH_EN
    jump        = 1'b0;
    jump_target = '0;
    call_push   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          ir_d    = instr;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: state_d = ST_WB;
      ST_WB: begin
        wr_w = (dec_wr_dest == WR_W);
        wr_f = (dec_wr_dest == WR_F);
        ret  = dec_ret;
`ifdef PIC_BRANCH_EN
        jump        = dec_branch;
        jump_target = dec_branch ? ir_q[TGT_W-1:0] : '0;
        call_push   = dec_branch & dec_call;
`endif
        state_d = skip_cond ? ST_SKIP : ST_IDLE;
      end
      ST_SKIP: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          skip_taken = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and instruction register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

endmodule
